vga_timing_gen: RTL and testbench

- Pixel-clock-domain stage directly downstream of the 100 MHz to 48.96 MHz iCE40 PLL.
- Consumes the PLL global output as its clock and the PLL LOCK flag as a qualifier.
- Holds the display pipeline idle until lock has been stable for a settle period, then generates VGA raster timing: sync, data-enable, pixel/line coordinates and frame/line strobes.
- Drops back to idle immediately on loss of lock.

---
 rtl/vga_timing_gen_if.sv | 54 +++++
 rtl/vga_timing_gen.sv | 203 ++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
//   Raster-timing bundle produced by vga_timing_gen and consumed by the
//   downstream pixel pipeline (pattern generator, framebuffer reader, DAC).
//
//   Signals
//     HSYNC        horizontal sync, asserted level set by the generator's HS_POL
//     VSYNC        vertical sync, asserted level set by the generator's VS_POL
//     DE           high while (HCOUNT, VCOUNT) lies in the visible area
//     HCOUNT[HW]   current pixel column
//     VCOUNT[VW]   current line
//     LINE_START   one-cycle pulse at HCOUNT == 0 while running
//     FRAME_START  one-cycle pulse at HCOUNT == 0 and VCOUNT == 0 while running
//     RUNNING      high while raster timing is being generated
//
//   Modports
//     master  the timing generator (drives everything)
//     slave   any consumer of the raster timing
// -----------------------------------------------------------------------------
interface vga_timing_gen_if #(
    parameter int HW = 11,
    parameter int VW = 10
);
    logic          HSYNC;
    logic          VSYNC;
    logic          DE;
    logic [HW-1:0] HCOUNT;
    logic [VW-1:0] VCOUNT;
    logic          LINE_START;
    logic          FRAME_START;
    logic          RUNNING;

    modport master (
        output HSYNC,
        output VSYNC,
        output DE,
        output HCOUNT,
        output VCOUNT,
        output LINE_START,
        output FRAME_START,
        output RUNNING
    );

    modport slave (
        input HSYNC,
        input VSYNC,
        input DE,
        input HCOUNT,
        input VCOUNT,
        input LINE_START,
        input FRAME_START,
        input RUNNING
    );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Pixel-clock-domain raster timing generator sitting directly behind the
//   iCE40 PLL. The PLL LOCK flag is synchronized into the pixel domain; the
//   display pipeline is held idle until the synchronized lock has been high
//   for LOCK_SETTLE consecutive cycles, after which VGA timing (sync, data
//   enable, coordinates, line/frame strobes) is generated continuously.
//   Any loss of lock drops straight back to idle on the next edge.
//
//   Ports
//     CLK     in   pixel clock (PLLOUTGLOBAL)
//     RESET   in   asynchronous, active-low reset
//     LOCK    in   PLL lock flag, asynchronous to CLK
//     vga     out  raster timing bundle (vga_timing_gen_if.master)
//
//   All outputs are registered together, so every field of the bundle
//   describes the same (HCOUNT, VCOUNT) point in any given cycle.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_ACTIVE    = 800,
    parameter int H_FP        = 56,
    parameter int H_SYNC      = 120,
    parameter int H_BP        = 64,
    parameter int V_ACTIVE    = 600,
    parameter int V_FP        = 37,
    parameter int V_SYNC      = 6,
    parameter int V_BP        = 23,
    parameter int HS_POL      = 1,
    parameter int VS_POL      = 1,
    parameter int LOCK_SETTLE = 1024,
    parameter int HW          = 11,
    parameter int VW          = 10
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 LOCK,
    vga_timing_gen_if.master     vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows as half-open ranges [BEG, END) in pixel / line units.
    localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // A settle period of 1 still needs a 1-bit counter.
    localparam int              SW          = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(LOCK_SETTLE - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Everything except the coordinates, registered as one group.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic line_start;
        logic frame_start;
        logic running;
    } flags_t;

    // Output flags for a raster point while running.
    function automatic flags_t flags_at(input logic [HW-1:0] h, input logic [VW-1:0] v);
        flags_t f;
        int     hi;
        int     vi;
        hi            = int'(h);
        vi            = int'(v);
        f.de          = (hi < H_ACTIVE) && (vi < V_ACTIVE);
        f.hsync       = ((hi >= H_SYNC_BEG) && (hi < H_SYNC_END)) ? HS_ON : ~HS_ON;
        f.vsync       = ((vi >= V_SYNC_BEG) && (vi < V_SYNC_END)) ? VS_ON : ~VS_ON;
        f.line_start  = (hi == 0);
        f.frame_start = (hi == 0) && (vi == 0);
        f.running     = 1'b1;
        return f;
    endfunction

    // Output flags while not running (identical to the reset values).
    function automatic flags_t flags_idle();
        flags_t f;
        f.hsync       = ~HS_ON;
        f.vsync       = ~VS_ON;
        f.de          = 1'b0;
        f.line_start  = 1'b0;
        f.frame_start = 1'b0;
        f.running     = 1'b0;
        return f;
    endfunction

    logic          lock_meta;
    logic          lock_s;
    state_t        state;
    logic [SW-1:0] settle_cnt;
    logic [HW-1:0] hcount_q;
    logic [VW-1:0] vcount_q;
    flags_t        flags_q;

    logic [HW-1:0] h_next;
    logic [VW-1:0] v_next;

    // Raster position one pixel after the current one, with line/frame wrap.
    always_comb begin
        h_next = hcount_q + 1'b1;
        v_next = vcount_q;
        if (hcount_q == H_LAST) begin
            h_next = '0;
            if (vcount_q == V_LAST) begin
                v_next = '0;
            end else begin
                v_next = vcount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
            hcount_q   <= '0;
            vcount_q   <= '0;
            flags_q    <= flags_idle();
        end else begin
            // LOCK comes from the PLL with no timing relationship to CLK.
            lock_meta <= LOCK;
            lock_s    <= lock_meta;

            case (state)
                WAIT_LOCK: begin
                    hcount_q <= '0;
                    vcount_q <= '0;
                    flags_q  <= flags_idle();
                    if (lock_s) begin
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    hcount_q <= '0;
                    vcount_q <= '0;
                    if (!lock_s) begin
                        // A single low sample restarts qualification from scratch.
                        flags_q <= flags_idle();
                        state   <= WAIT_LOCK;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        // The first RUN cycle presents the top-left pixel.
                        flags_q <= flags_at('0, '0);
                        state   <= RUN;
                    end else begin
                        flags_q    <= flags_idle();
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        // Abandon the frame immediately; no partial completion.
                        hcount_q <= '0;
                        vcount_q <= '0;
                        flags_q  <= flags_idle();
                        state    <= WAIT_LOCK;
                    end else begin
                        hcount_q <= h_next;
                        vcount_q <= v_next;
                        flags_q  <= flags_at(h_next, v_next);
                    end
                end

                default: begin
                    hcount_q <= '0;
                    vcount_q <= '0;
                    flags_q  <= flags_idle();
                    state    <= WAIT_LOCK;
                end
            endcase
        end
    end

    assign vga.HSYNC       = flags_q.hsync;
    assign vga.VSYNC       = flags_q.vsync;
    assign vga.DE          = flags_q.de;
    assign vga.HCOUNT      = hcount_q;
    assign vga.VCOUNT      = vcount_q;
    assign vga.LINE_START  = flags_q.line_start;
    assign vga.FRAME_START = flags_q.frame_start;
    assign vga.RUNNING     = flags_q.running;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//   Bench for vga_timing_gen using a small raster (H 4/1/2/1, V 3/1/1/1) so
//   whole frames fit in a few dozen cycles. A startup vector table, a few
//   hand-written corner sequences and a randomized LOCK stream are all
//   compared against a behavioural model: the generator runs once the
//   synchronized lock has been high for LOCK_SETTLE+1 consecutive edges, and
//   while running the raster position is simply the number of edges since
//   entry, split into column and line with division and modulo.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int H_ACTIVE    = 4;
    localparam int H_FP        = 1;
    localparam int H_SYNC      = 2;
    localparam int H_BP        = 1;
    localparam int V_ACTIVE    = 3;
    localparam int V_FP        = 1;
    localparam int V_SYNC      = 1;
    localparam int V_BP        = 1;
    localparam int HS_POL      = 1;
    localparam int VS_POL      = 0;
    localparam int LOCK_SETTLE = 6;
    localparam int HW          = 3;
    localparam int VW          = 3;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);
    localparam int RISE_LAT = 3 + LOCK_SETTLE;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;
    logic LOCK  = 1'b0;

    vga_timing_gen_if #(.HW(HW), .VW(VW)) vif ();

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .LOCK_SETTLE(LOCK_SETTLE),
        .HW(HW), .VW(VW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .LOCK  (LOCK),
        .vga   (vif)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Behavioural model state
    logic m_d0, m_d1;     // LOCK as seen one and two edges ago
    int   m_streak;       // consecutive edges with synchronized lock high
    bit   m_run;
    int   m_pos;          // edges since entering RUN

    typedef struct {
        logic lock;
        logic run;
        int   h;
        int   v;
        logic de;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_d0     = 1'b0;
        m_d1     = 1'b0;
        m_streak = 0;
        m_run    = 1'b0;
        m_pos    = 0;
    endtask

    task automatic model_edge();
        logic s;
        if (!RESET) begin
            model_reset();
        end else begin
            s    = m_d1;
            m_d1 = m_d0;
            m_d0 = LOCK;
            if (m_run) begin
                if (s) begin
                    m_pos++;
                end else begin
                    m_run    = 1'b0;
                    m_streak = 0;
                end
            end else begin
                m_streak = s ? m_streak + 1 : 0;
                if (m_streak == LOCK_SETTLE + 1) begin
                    m_run = 1'b1;
                    m_pos = 0;
                end
            end
        end
    endtask

    task automatic model_check();
        int   h, v;
        logic de, hs, vs, ls, fs;
        if (m_run) begin
            h  = m_pos % H_TOTAL;
            v  = (m_pos / H_TOTAL) % V_TOTAL;
            de = (h < H_ACTIVE) && (v < V_ACTIVE);
            hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HS_ON : !HS_ON;
            vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VS_ON : !VS_ON;
            ls = (h == 0);
            fs = (h == 0) && (v == 0);
        end else begin
            h = 0; v = 0; de = 1'b0; hs = !HS_ON; vs = !VS_ON; ls = 1'b0; fs = 1'b0;
        end
        chk("m_running", 32'(vif.RUNNING), 32'(m_run));
        chk("m_hcount", 32'(vif.HCOUNT), h);
        chk("m_vcount", 32'(vif.VCOUNT), v);
        chk("m_de", 32'(vif.DE), 32'(de));
        chk("m_hsync", 32'(vif.HSYNC), 32'(hs));
        chk("m_vsync", 32'(vif.VSYNC), 32'(vs));
        chk("m_line_start", 32'(vif.LINE_START), 32'(ls));
        chk("m_frame_start", 32'(vif.FRAME_START), 32'(fs));
    endtask

    // One clock edge with the given LOCK level, then sample and compare.
    task automatic tick(input logic lk);
        LOCK = lk;
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        model_check();
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_running"}, 32'(vif.RUNNING), 0);
        chk({nm, "_hcount"}, 32'(vif.HCOUNT), 0);
        chk({nm, "_vcount"}, 32'(vif.VCOUNT), 0);
        chk({nm, "_de"}, 32'(vif.DE), 0);
        chk({nm, "_hsync"}, 32'(vif.HSYNC), 32'(!HS_ON));
        chk({nm, "_vsync"}, 32'(vif.VSYNC), 32'(!VS_ON));
        chk({nm, "_frame_start"}, 32'(vif.FRAME_START), 0);
        chk({nm, "_line_start"}, 32'(vif.LINE_START), 0);
    endtask

    // Count edges of LOCK=1 until RUNNING rises (bounded).
    task automatic ticks_to_run(output int n);
        n = 0;
        do begin
            tick(1'b1);
            n++;
        end while (vif.RUNNING !== 1'b1 && n < 4 * RISE_LAT);
    endtask

    initial begin
        int n, period, de_cnt, vs_cnt, seg, lvl;

        // Startup vectors after reset release with LOCK held high.
        for (int i = 0; i < 8; i++) tbl[i] = '{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 2, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b1, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 5, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 6, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 1'b1, 7, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 0, 1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        model_reset();
        RESET = 1'b0;
        LOCK  = 1'b1;
        for (int i = 0; i < 5; i++) tick(1'b1);
        check_idle("reset");
        RESET = 1'b1;

        for (int i = 0; i < 17; i++) begin
            LOCK = tbl[i].lock;
            @(posedge CLK);
            cyc++;
            model_edge();
            #1;
            chk($sformatf("tbl%0d_running", i), 32'(vif.RUNNING), 32'(tbl[i].run));
            chk($sformatf("tbl%0d_hcount", i), 32'(vif.HCOUNT), tbl[i].h);
            chk($sformatf("tbl%0d_vcount", i), 32'(vif.VCOUNT), tbl[i].v);
            chk($sformatf("tbl%0d_de", i), 32'(vif.DE), 32'(tbl[i].de));
            chk($sformatf("tbl%0d_hsync", i), 32'(vif.HSYNC), 32'(tbl[i].hs));
            chk($sformatf("tbl%0d_vsync", i), 32'(vif.VSYNC), 32'(tbl[i].vs));
            chk($sformatf("tbl%0d_line_start", i), 32'(vif.LINE_START), 32'(tbl[i].ls));
            chk($sformatf("tbl%0d_frame_start", i), 32'(vif.FRAME_START), 32'(tbl[i].fs));
        end

        // Whole-frame statistics between consecutive FRAME_START pulses.
        n = 0;
        while (vif.FRAME_START !== 1'b1 && n < 200) begin
            tick(1'b1);
            n++;
        end
        chk("frame_found", 32'(n < 200), 1);
        period = 0; de_cnt = 0; vs_cnt = 0;
        do begin
            if (vif.DE === 1'b1) de_cnt++;
            if (vif.VSYNC === VS_ON) begin
                vs_cnt++;
                chk("vsync_line", 32'(vif.VCOUNT), V_ACTIVE + V_FP);
            end
            tick(1'b1);
            period++;
        end while (vif.FRAME_START !== 1'b1 && period < 200);
        chk("frame_period", period, H_TOTAL * V_TOTAL);
        chk("frame_de_cycles", de_cnt, H_ACTIVE * V_ACTIVE);
        chk("frame_vsync_cycles", vs_cnt, H_TOTAL * V_SYNC);

        // Lock loss mid-frame: idle exactly three edges after LOCK falls.
        n = 0;
        while (!(vif.HCOUNT == 3'd3 && vif.VCOUNT == 3'd2) && n < 200) begin
            tick(1'b1);
            n++;
        end
        chk("loss_point_found", 32'(n < 200), 1);
        tick(1'b0);
        chk("loss_e1_running", 32'(vif.RUNNING), 1);
        tick(1'b0);
        chk("loss_e2_running", 32'(vif.RUNNING), 1);
        tick(1'b0);
        check_idle("loss_e3");
        ticks_to_run(n);
        chk("relock_latency", n, RISE_LAT);
        chk("relock_hcount", 32'(vif.HCOUNT), 0);
        chk("relock_vcount", 32'(vif.VCOUNT), 0);
        chk("relock_frame_start", 32'(vif.FRAME_START), 1);

        // Settle glitch: a one-cycle drop restarts the full settle period.
        for (int i = 0; i < 4; i++) tick(1'b0);
        for (int i = 0; i < LOCK_SETTLE - 2; i++) tick(1'b1);
        tick(1'b0);
        ticks_to_run(n);
        chk("glitch_latency", n, RISE_LAT);
        chk("glitch_frame_start", 32'(vif.FRAME_START), 1);

        // Asynchronous reset between edges, mid-line.
        n = 0;
        while (vif.HCOUNT != 3'd2 && n < 50) begin
            tick(1'b1);
            n++;
        end
        chk("areset_point_found", 32'(n < 50), 1);
        #2;
        RESET = 1'b0;
        #1;
        check_idle("areset");
        model_reset();
        tick(1'b1);
        tick(1'b1);
        RESET = 1'b1;
        ticks_to_run(n);
        chk("areset_restart_latency", n, RISE_LAT);
        chk("areset_restart_frame_start", 32'(vif.FRAME_START), 1);

        // Randomized LOCK stream, mostly long high stretches.
        for (int k = 0; k < 120; k++) begin
            lvl = ($urandom_range(0, 3) != 0) ? 1 : 0;
            seg = lvl != 0 ? $urandom_range(1, 40) : $urandom_range(1, 4);
            for (int j = 0; j < seg; j++) tick(lvl != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
